alu_seq_exec: RTL and testbench
===============================

ALU_SEQ_EXEC -- requirements
Module: alu_seq_exec

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits; legal values are powers of two from 8 to 64.
REQ-002 Derived constant SHW = $clog2(WIDTH), the shift-amount width.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 in_valid  input  1  operation request present.
REQ-006 in_ready  output  1  block can accept a request.
REQ-007 op  input  4  Operation code (alu_pkg::alu_op_e).
REQ-008 a  input  WIDTH  operand A.
REQ-009 b  input  WIDTH  operand B; for shifts, only b[SHW-1:0] is used as the shift amount.
REQ-010 out_valid  output  1  result present.
REQ-011 out_ready  input  1  consumer accepts the result.
REQ-012 result  output  WIDTH  operation result.
REQ-013 zero  output  1  high when result == 0.
REQ-014 illegal  output  1  high when the accepted op code is not in REQ-015.

Function
REQ-015 Op encoding:
- 0000 AND, 0001 OR, 0010 ADD, 0011 SUB, 0100 XOR
- 0101 SRL, 0110 SLL, 0111 SRA
- 1000 EQ (result 1 if a==b, else 0)
- 1100 SLT (signed; result 1 if a<b, else 0)
REQ-016 FSM states are IDLE, EXEC, SHIFT and DONE; reset enters IDLE.
REQ-017 in_ready = 1 only in IDLE.
REQ-018 A transfer occurs when in_valid && in_ready; op, a and b are captured into internal registers and the FSM moves to EXEC.
REQ-019 EXEC, non-shift op: the result is computed from the captured registers, registered, and the FSM moves to DONE; out_valid rises on the cycle after the transfer (latency 2 edges).
REQ-020 EXEC, shift op with amount 0: result = a, then DONE, with the same latency as REQ-019.
REQ-021 EXEC, shift op with amount n>0: the working register is loaded with a, the counter is loaded with n, and the FSM moves to SHIFT.
REQ-022 SHIFT: each cycle shifts the working register by exactly one bit (SRL fills 0; SLL fills 0; SRA replicates the MSB) and decrements the counter; when the counter reaches 1, the final shift is applied and the FSM moves to DONE; total cycles in SHIFT = n.
REQ-023 ADD/SUB wrap modulo 2^WIDTH; no carry or overflow output.
REQ-024 Undefined op codes: result = 0, illegal = 1, latency as REQ-019; otherwise illegal = 0.
REQ-025 DONE: out_valid = 1; result, zero and illegal are stable until out_valid && out_ready; the FSM then returns to IDLE.
REQ-026 When out_ready is already high on entering DONE, exactly one cycle of out_valid occurs; there is no back-to-back acceptance (in_ready = 0 in DONE).
REQ-027 Input changes outside a transfer have no effect on a result in progress.

Reset
REQ-028 When rst_n = 0 at a clock edge: state = IDLE, out_valid = 0, result = 0, zero = 0, illegal = 0, and the counter and working registers are cleared.
REQ-029 Reset in any state, including mid-SHIFT or DONE, aborts the operation with no output produced; in_ready = 1 on the first edge after rst_n returns high.

Structure
REQ-030 Package alu_pkg holds the alu_op_e enum (REQ-015 codes) and the FSM state enum.
REQ-031 The one-bit-per-cycle shifter is a sub-module, alu_shift_step (combinational: value, op -> value shifted by one bit).

Verification
REQ-032 ADD a=0x7FFFFFFF, b=1 -> result 0x80000000, out_valid on the cycle after the transfer, zero=0.
REQ-033 SUB a=5, b=5 -> result 0, zero=1; then EQ with a=3, b=3 -> result 1.
REQ-034 SRA a=0x80000000, b=31 -> result 0xFFFFFFFF after exactly 31 SHIFT cycles; SLL with b=0 -> result = a at latency 2.
REQ-035 SLT a=0xFFFFFFFF, b=1 -> result 1; op=1111 -> result 0, illegal=1.
REQ-036 Hold out_ready=0 for 5 cycles in DONE -> result stable and in_ready=0 throughout; pulse out_ready -> returns to IDLE, in_ready=1 on the next cycle.
REQ-037 Assert rst_n=0 mid-SHIFT (SRL, b=20, at cycle 7) -> out_valid never rises, all outputs 0, next request completes normally.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU.
//   alu_op_e    - operation codes accepted on the op port
//   alu_state_e - control FSM states
//   is_shift_op - true for the bit-serial shift operations
//   is_legal_op - true for every defined operation code
package alu_pkg;

    typedef enum logic [3:0] {
        OP_AND = 4'b0000,
        OP_OR  = 4'b0001,
        OP_ADD = 4'b0010,
        OP_SUB = 4'b0011,
        OP_XOR = 4'b0100,
        OP_SRL = 4'b0101,
        OP_SLL = 4'b0110,
        OP_SRA = 4'b0111,
        OP_EQ  = 4'b1000,
        OP_SLT = 4'b1100
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_EXEC  = 2'b01,
        ST_SHIFT = 2'b10,
        ST_DONE  = 2'b11
    } alu_state_e;

    function automatic logic is_shift_op(input logic [3:0] op);
        logic res;
        case (op)
            OP_SRL, OP_SLL, OP_SRA: res = 1'b1;
            default:                res = 1'b0;
        endcase
        return res;
    endfunction

    function automatic logic is_legal_op(input logic [3:0] op);
        logic res;
        case (op)
            OP_AND, OP_OR, OP_ADD, OP_SUB, OP_XOR,
            OP_SRL, OP_SLL, OP_SRA, OP_EQ, OP_SLT: res = 1'b1;
            default:                               res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/alu_shift_step.sv
// One-bit shifter used once per cycle while the ALU is in its SHIFT state.
//   value_i - working value
//   op_i    - operation code (SRL, SLL or SRA shift; anything else passes through)
//   value_o - value_i shifted by exactly one bit
module alu_shift_step
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] value_i,
    input  logic [3:0]       op_i,
    output logic [WIDTH-1:0] value_o
);

    // Single-bit shift; SRA keeps the sign bit in place and copies it down.
    always_comb begin
        value_o = value_i;
        case (op_i)
            OP_SRL:  value_o = {1'b0, value_i[WIDTH-1:1]};
            OP_SLL:  value_o = {value_i[WIDTH-2:0], 1'b0};
            OP_SRA:  value_o = {value_i[WIDTH-1], value_i[WIDTH-1:1]};
            default: value_o = value_i;
        endcase
    end

endmodule

// File: rtl/alu_seq_exec.sv
// Sequential ALU with a valid/ready request port and a valid/ready result port.
// Single-cycle ops finish two edges after the transfer; shifts run one bit per
// cycle in a SHIFT state for as many cycles as the shift amount.
//   clk, rst_n          - clock, synchronous active-low reset
//   in_valid / in_ready - request handshake (ready only while idle)
//   op, a, b            - operation code and operands (b[SHW-1:0] = shift amount)
//   out_valid/out_ready - result handshake
//   result, zero        - result value and its zero flag
//   illegal             - accepted op code was undefined
module alu_seq_exec
    import alu_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegal
);

    localparam logic [SHW-1:0]   CNT_ZERO = {SHW{1'b0}};
    localparam logic [SHW-1:0]   CNT_ONE  = {{(SHW-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] RES_ZERO = {WIDTH{1'b0}};

    alu_state_e       state_q, state_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             illegal_q, illegal_d;
    logic             out_valid_q, out_valid_d;
    logic             in_ready_q, in_ready_d;

    logic [WIDTH-1:0] exec_res_s;
    logic [WIDTH-1:0] step_res_s;
    logic [SHW-1:0]   shamt_s;

    assign shamt_s = b_q[SHW-1:0];

    alu_shift_step #(
        .WIDTH (WIDTH)
    ) u_shift_step (
        .value_i (work_q),
        .op_i    (op_q),
        .value_o (step_res_s)
    );

    // Single-cycle result from the captured operands. Shift ops only land
    // here with a zero amount, where the result is simply a.
    always_comb begin
        exec_res_s = RES_ZERO;
        case (op_q)
            OP_AND:                 exec_res_s = a_q & b_q;
            OP_OR:                  exec_res_s = a_q | b_q;
            OP_ADD:                 exec_res_s = a_q + b_q;
            OP_SUB:                 exec_res_s = a_q - b_q;
            OP_XOR:                 exec_res_s = a_q ^ b_q;
            OP_SRL, OP_SLL, OP_SRA: exec_res_s = a_q;
            OP_EQ:                  exec_res_s = {{(WIDTH-1){1'b0}}, (a_q == b_q)};
            OP_SLT:                 exec_res_s = {{(WIDTH-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
            default:                exec_res_s = RES_ZERO;
        endcase
    end

    // Next-state and datapath next values for the control FSM.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        work_d      = work_q;
        cnt_d       = cnt_q;
        result_d    = result_q;
        zero_d      = zero_q;
        illegal_d   = illegal_q;
        out_valid_d = out_valid_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready_q) begin
                    op_d    = op;
                    a_d     = a;
                    b_d     = b;
                    state_d = ST_EXEC;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EXEC: begin
                if (is_shift_op(op_q) && (shamt_s != CNT_ZERO)) begin
                    work_d  = a_q;
                    cnt_d   = shamt_s;
                    state_d = ST_SHIFT;
                end else begin
                    result_d    = exec_res_s;
                    zero_d      = (exec_res_s == RES_ZERO);
                    illegal_d   = !is_legal_op(op_q);
                    out_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end
            end
            ST_SHIFT: begin
                work_d = step_res_s;
                cnt_d  = cnt_q - CNT_ONE;
                // The step applied on the count-of-one cycle is the last one.
                if (cnt_q == CNT_ONE) begin
                    result_d    = step_res_s;
                    zero_d      = (step_res_s == RES_ZERO);
                    illegal_d   = 1'b0;
                    out_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
        in_ready_d = (state_d == ST_IDLE);
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            op_q        <= 4'b0000;
            a_q         <= RES_ZERO;
            b_q         <= RES_ZERO;
            work_q      <= RES_ZERO;
            cnt_q       <= CNT_ZERO;
            result_q    <= RES_ZERO;
            zero_q      <= 1'b0;
            illegal_q   <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            work_q      <= work_d;
            cnt_q       <= cnt_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            illegal_q   <= illegal_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign zero      = zero_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_seq_exec.sv
// Self-checking bench for alu_seq_exec (WIDTH = 32): directed cases with
// literal expectations plus randomized traffic against a behavioural model.
module tb_alu_seq_exec;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        illegal;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    // Model state: pending result, cycles still to go, result on offer.
    bit          m_busy      = 1'b0;
    int          m_wait      = 0;
    bit          m_valid     = 1'b0;
    bit          m_after_rst = 1'b0;
    logic [31:0] m_res       = 32'd0;
    logic        m_zero      = 1'b0;
    logic        m_ill       = 1'b0;
    logic [31:0] p_res       = 32'd0;
    logic        p_ill       = 1'b0;

    alu_seq_exec #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .illegal   (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_result(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        int unsigned sh;
        logic [31:0] r;
        sh = y & 32'd31;
        case (o)
            4'd0:    r = x & y;
            4'd1:    r = x | y;
            4'd2:    r = x + y;
            4'd3:    r = x - y;
            4'd4:    r = x ^ y;
            4'd5:    r = x >> sh;
            4'd6:    r = x << sh;
            4'd7:    r = $signed(x) >>> sh;
            4'd8:    r = (x == y) ? 32'd1 : 32'd0;
            4'd12:   r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    function automatic logic ref_illegal(input logic [3:0] o);
        return !((o <= 4'd8) || (o == 4'd12));
    endfunction

    // Extra cycles beyond the basic latency: the shift amount for shifts.
    function automatic int ref_extra(input logic [3:0] o, input logic [31:0] y);
        if (o == 4'd5 || o == 4'd6 || o == 4'd7) return int'(y & 32'd31);
        return 0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a transfer schedules its result 1+n edges later,
    // the result is then on offer until the consumer takes it.
    always @(posedge clk) begin
        if (!rst_n) begin
            m_busy      = 1'b0;
            m_valid     = 1'b0;
            m_wait      = 0;
            m_res       = 32'd0;
            m_zero      = 1'b0;
            m_ill       = 1'b0;
            m_after_rst = 1'b1;
        end else if (m_valid) begin
            if (out_ready) m_valid = 1'b0;
        end else if (m_busy) begin
            m_wait = m_wait - 1;
            if (m_wait == 0) begin
                m_busy  = 1'b0;
                m_valid = 1'b1;
                m_res   = p_res;
                m_zero  = (p_res == 32'd0);
                m_ill   = p_ill;
            end
        end else if (in_valid) begin
            p_res       = ref_result(op, a, b);
            p_ill       = ref_illegal(op);
            m_wait      = 1 + ref_extra(op, b);
            m_busy      = 1'b1;
            m_after_rst = 1'b0;
        end
    end

    // Compare process: DUT outputs against the model every cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            check("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
            check("in_ready", {31'd0, in_ready}, {31'd0, !m_busy && !m_valid});
            if (m_valid || m_after_rst) begin
                check("result", result, m_res);
                check("zero", {31'd0, zero}, {31'd0, m_zero});
                check("illegal", {31'd0, illegal}, {31'd0, m_ill});
            end
        end
    end

    // Present a request (called at a negedge) and return just after the transfer edge.
    task automatic send(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        int n;
        op = o; a = x; b = y; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            n_chk++; n_fail++;
            $display("FAIL send_timeout: in_ready stayed 0, expected 1");
        end
        @(posedge clk);
    endtask

    // Full transaction; literal expectations are checked when lit is set.
    task automatic run(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y, input int hold,
                       input bit lit, input logic [31:0] e_res, input logic e_zero, input logic e_ill, input int e_lat);
        int k;
        send(o, x, y);
        k = 0;
        do begin
            @(negedge clk);
            k++;
            if (k == 1) begin
                in_valid = 1'b0;
                a = $urandom; b = $urandom; op = 4'($urandom_range(0, 15));
                if (hold == 0) out_ready = 1'b1;
            end
        end while (!out_valid && k < 100);
        if (!out_valid) begin
            n_chk++; n_fail++;
            $display("FAIL done_timeout: out_valid stayed 0 after %0d cycles, expected 1", k);
        end
        if (lit) begin
            check("lit_latency", k, e_lat);
            check("lit_result", result, e_res);
            check("lit_zero", {31'd0, zero}, {31'd0, e_zero});
            check("lit_illegal", {31'd0, illegal}, {31'd0, e_ill});
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (lit) begin
                check("lit_hold_result", result, e_res);
                check("lit_hold_in_ready", {31'd0, in_ready}, 32'd0);
                check("lit_hold_out_valid", {31'd0, out_valid}, 32'd1);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        if (lit) begin
            check("lit_ack_in_ready", {31'd0, in_ready}, 32'd1);
            check("lit_ack_out_valid", {31'd0, out_valid}, 32'd0);
        end
    endtask

    initial begin
        logic [3:0]  r_op;
        logic [31:0] r_b;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        op = 4'd0; a = 32'd0; b = 32'd0;
        repeat (2) @(posedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_result", result, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run(4'b0010, 32'h7FFF_FFFF, 32'd1,  1, 1'b1, 32'h8000_0000, 1'b0, 1'b0, 2);
        run(4'b0011, 32'd5,         32'd5,  0, 1'b1, 32'd0,         1'b1, 1'b0, 2);
        run(4'b1000, 32'd3,         32'd3,  0, 1'b1, 32'd1,         1'b0, 1'b0, 2);
        run(4'b0111, 32'h8000_0000, 32'd31, 1, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 33);
        run(4'b0110, 32'h1234_5678, 32'd0,  0, 1'b1, 32'h1234_5678, 1'b0, 1'b0, 2);
        run(4'b1100, 32'hFFFF_FFFF, 32'd1,  0, 1'b1, 32'd1,         1'b0, 1'b0, 2);
        run(4'b1111, 32'hDEAD_BEEF, 32'd7,  0, 1'b1, 32'd0,         1'b1, 1'b1, 2);
        run(4'b0100, 32'hF0F0_1234, 32'h0F0F_0000, 5, 1'b1, 32'hFFFF_1234, 1'b0, 1'b0, 2);
        run(4'b0101, 32'h8000_0001, 32'd4,  0, 1'b1, 32'h0800_0000, 1'b0, 1'b0, 6);

        // Reset in the middle of a long SRL: nothing may come out.
        send(4'b0101, 32'hABCD_EF01, 32'd20);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_result", result, 32'd0);
        check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        repeat (25) @(negedge clk);
        run(4'b0001, 32'h0000_00F0, 32'h0000_000F, 0, 1'b1, 32'h0000_00FF, 1'b0, 1'b0, 2);

        // Randomized traffic, checked by the model only.
        for (int t = 0; t < 60; t++) begin
            r_op = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) r_b = $urandom & 32'hFFFF_FFE0;
            else r_b = $urandom;
            run(r_op, $urandom, r_b, $urandom_range(0, 3), 1'b0, 32'd0, 1'b0, 1'b0, 0);
        end

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
